video_src_gen: RTL
==================

# video_src_gen

Video stream source that produces the `do_o/de_o/hs_o/vs_o` pixel bus consumed by the scaler input (line start = `hs` falling edge, frame start = `vs` rising edge). It generates programmable frame timing and a selectable test pattern. It optionally inserts empty cycles between pixels, matching the sparse output format. It sits in front of the scaler in benches and in bring-up designs as the transmitter end of the pixel-bus protocol.

## Interface
- PIXEL_WIDTH, 12, pixel data width
- CNT_WIDTH, 16, width of all size/blank registers and counters
- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; starts frames, stops at end of current frame when low
- reg_h_active  in  CNT_WIDTH  active pixels per line
- reg_h_blank  in  CNT_WIDTH  blanking cycles per line (hs_o high)
- reg_v_active  in  CNT_WIDTH  active lines per frame
- reg_v_blank  in  CNT_WIDTH  blanking lines per frame (vs_o high)
- reg_sparse  in  4  empty cycles after each active pixel
- reg_pattern  in  2  0 h-ramp, 1 v-ramp, 2 checker, 3 constant
- reg_const  in  PIXEL_WIDTH  value for pattern 3
- do_o  out  PIXEL_WIDTH  pixel data, 0 when de_o low
- de_o  out  1  pixel valid
- hs_o  out  1  high during horizontal blanking
- vs_o  out  1  high during vertical blanking lines
- frame_cnt_o  out  CNT_WIDTH  completed frames, wraps

## Operation
- States: IDLE, HBLANK, ACTIVE. Counters: `hcnt` (cycles in phase), `px` (pixel x), `sp` (sparse gap), `ln` (line index over v_blank+v_active).
- All `reg_*` inputs are latched into shadow registers when leaving IDLE and on each frame wrap. They never change mid-frame.
- Clamps at latch: h_active, v_active, v_blank of 0 are treated as 1. h_blank < 2 is treated as 2.
- IDLE: all outputs 0. When enable=1, go to HBLANK with ln=0.
- HBLANK: hs_o=1 for h_blank cycles, then go to ACTIVE.
- vs_o=1 on every cycle of lines ln < v_blank (blank lines), and 0 on active lines.
- ACTIVE: hs_o=0. It lasts h_active*(sparse+1) cycles: one cycle with de_o=1, then `sparse` cycles with de_o=0, repeated. After the last gap (or the last pixel when sparse=0), go to HBLANK with ln+1.
- On blank lines, ACTIVE runs the same cycle count but de_o stays 0.
- Frame end: after the last active line, ln wraps to 0 and frame_cnt_o increments (modulo 2^CNT_WIDTH). If enable=0 at that moment, go to IDLE; otherwise re-latch regs and go to HBLANK.
- Pixel value, with y = ln - v_blank and truncation to PIXEL_WIDTH:
  - pattern 0: px
  - pattern 1: y
  - pattern 2: all ones if (px[3] ^ y[3]), else 0
  - pattern 3: reg_const
- rst_n low at any time forces IDLE, clears counters and zeroes all outputs asynchronously. Regs re-latch on the next start.

## Timing
- All outputs are registered. Every output's reset value is 0.
- Start latency: enable sampled high in IDLE at cycle N gives hs_o=1 and vs_o=1 at cycle N+1.
- Line period: h_blank + h_active*(sparse+1) cycles.
- Frame period: (v_blank + v_active) × line period.
- vs_o rises in the same cycle as the hs_o rise of line 0. vs_o falls in the same cycle as the hs_o rise of the first active line.
- de_o is never 1 while hs_o=1 or vs_o=1.
- The first de_o of a line is in the cycle after the hs_o falling edge, i.e. the first ACTIVE cycle.
- enable dropping mid-frame has no effect until the frame end. enable toggling high-low-high within one frame causes no restart.

## Test plan
- Reset: hold rst_n=0 with enable=1 → all outputs 0. Release rst_n → hs_o=vs_o=1 one cycle after the first enabled edge.
- h_active=4, h_blank=2, v_active=2, v_blank=1, sparse=0, pattern 0:
  - frame is 18 cycles; hs_o is 1,1 then 0,0,0,0 per line
  - de_o is high only on lines 1–2, with do_o = 0,1,2,3
  - frame_cnt_o=1 after cycle 18
- Same timing with sparse=2: ACTIVE phase is 12 cycles, de_o pattern is 1,0,0 repeated 4×, and do_o stays 0 during gaps.
- Pattern 2, h_active=32, v_active=16: do_o toggles every 8 pixels and the phase inverts every 8 lines. Pattern 3 with reg_const=0xABC gives do_o=0xABC on every de_o cycle.
- Write reg_h_active=8 mid-frame: the current frame keeps 4 pixels/line and the next frame has 8.
- Deassert enable mid-frame: the frame completes, frame_cnt_o increments, outputs are 0 thereafter. reg_h_blank=0 or 1 yields 2 blank cycles.

Source files
------------

// File: rtl/video_src_gen.sv
// video_src_gen: pixel-bus source with programmable frame timing, sparse gaps and test patterns.
module video_src_gen #(
  parameter int PIXEL_WIDTH = 12,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [CNT_WIDTH-1:0]   reg_h_active,
  input  logic [CNT_WIDTH-1:0]   reg_h_blank,
  input  logic [CNT_WIDTH-1:0]   reg_v_active,
  input  logic [CNT_WIDTH-1:0]   reg_v_blank,
  input  logic [3:0]             reg_sparse,
  input  logic [1:0]             reg_pattern,
  input  logic [PIXEL_WIDTH-1:0] reg_const,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic [CNT_WIDTH-1:0]   frame_cnt_o
);
  typedef enum logic [1:0] {IDLE, HBLANK, ACTIVE} state_t;
  localparam int LW = CNT_WIDTH + 1;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d, px_q, px_d, frame_q, frame_d;
  logic [3:0] sp_q, sp_d, spr_q, spr_d;
  logic [LW-1:0] ln_q, ln_d;
  logic [CNT_WIDTH-1:0] ha_q, ha_d, hb_q, hb_d, va_q, va_d, vb_q, vb_d;
  logic [1:0] pat_q, pat_d;
  logic [PIXEL_WIDTH-1:0] cst_q, cst_d, do_q, do_d, y, pix;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic latch, line_end, frame_end;
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    px_d      = px_q;
    sp_d      = sp_q;
    ln_d      = ln_q;
    frame_d   = frame_q;
    latch     = 1'b0;
    line_end  = state_q == ACTIVE && sp_q == spr_q && px_q == ha_q - 1'b1;
    frame_end = line_end && ln_q == LW'(vb_q) + LW'(va_q) - 1'b1;
    case (state_q)
      IDLE: if (enable) begin
        state_d = HBLANK;
        hcnt_d  = '0;
        ln_d    = '0;
        latch   = 1'b1;
      end
      HBLANK: if (hcnt_q == hb_q - 1'b1) begin
        state_d = ACTIVE;
        px_d    = '0;
        sp_d    = '0;
      end else hcnt_d = hcnt_q + 1'b1;
      ACTIVE: if (sp_q != spr_q) sp_d = sp_q + 4'd1;
      else if (!line_end) begin
        px_d = px_q + 1'b1;
        sp_d = '0;
      end else if (!frame_end) begin
        state_d = HBLANK;
        hcnt_d  = '0;
        ln_d    = ln_q + 1'b1;
      end else begin
        // frame wrap: regs re-latch only when continuing into another frame
        frame_d = frame_q + 1'b1;
        ln_d    = '0;
        hcnt_d  = '0;
        state_d = enable ? HBLANK : IDLE;
        latch   = enable;
      end
      default: state_d = IDLE;
    endcase
    ha_d  = latch ? ((reg_h_active == '0) ? CNT_WIDTH'(1) : reg_h_active) : ha_q;
    hb_d  = latch ? ((reg_h_blank < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : reg_h_blank) : hb_q;
    va_d  = latch ? ((reg_v_active == '0) ? CNT_WIDTH'(1) : reg_v_active) : va_q;
    vb_d  = latch ? ((reg_v_blank == '0) ? CNT_WIDTH'(1) : reg_v_blank) : vb_q;
    spr_d = latch ? reg_sparse : spr_q;
    pat_d = latch ? reg_pattern : pat_q;
    cst_d = latch ? reg_const : cst_q;
    // outputs are derived from the next state so they register alongside it
    y     = PIXEL_WIDTH'(ln_d - LW'(vb_d));
    pix   = pat_d == 2'd0 ? PIXEL_WIDTH'(px_d) :
            pat_d == 2'd1 ? y :
            pat_d == 2'd2 ? {PIXEL_WIDTH{px_d[3] ^ y[3]}} : cst_d;
    hs_d  = state_d == HBLANK;
    vs_d  = state_d != IDLE && ln_d < LW'(vb_d);
    de_d  = state_d == ACTIVE && sp_d == 4'd0 && !vs_d;
    do_d  = de_d ? pix : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      px_q    <= '0;
      sp_q    <= '0;
      ln_q    <= '0;
      frame_q <= '0;
      ha_q    <= '0;
      hb_q    <= '0;
      va_q    <= '0;
      vb_q    <= '0;
      spr_q   <= '0;
      pat_q   <= '0;
      cst_q   <= '0;
      do_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      px_q    <= px_d;
      sp_q    <= sp_d;
      ln_q    <= ln_d;
      frame_q <= frame_d;
      ha_q    <= ha_d;
      hb_q    <= hb_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      spr_q   <= spr_d;
      pat_q   <= pat_d;
      cst_q   <= cst_d;
      do_q    <= do_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end
  assign do_o        = do_q;
  assign de_o        = de_q;
  assign hs_o        = hs_q;
  assign vs_o        = vs_q;
  assign frame_cnt_o = frame_q;
endmodule
